// File: rtl/multiplier_phase_sequencer_pkg.sv
// Shared types for the matrix-multiplier phase sequencer: state encoding,
// child indices and the state-to-child ownership map.
package multiplier_seq_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD_A  = 3'd1,
        LOAD_B  = 3'd2,
        LOAD_AB = 3'd3,
        COMPUTE = 3'd4,
        STORE   = 3'd5,
        DONE    = 3'd6
    } seq_state_e;

    localparam int N_CHILD    = 4;
    localparam int CH_LOAD_A  = 0;
    localparam int CH_LOAD_B  = 1;
    localparam int CH_COMPUTE = 2;
    localparam int CH_STORE   = 3;

    // Children whose handshake is live while the FSM sits in st.
    function automatic logic [N_CHILD-1:0] phase_owner(seq_state_e st);
        logic [N_CHILD-1:0] m;
        m = '0;
        case (st)
            LOAD_A:  m[CH_LOAD_A]  = 1'b1;
            LOAD_B:  m[CH_LOAD_B]  = 1'b1;
            LOAD_AB: begin
                m[CH_LOAD_A] = 1'b1;
                m[CH_LOAD_B] = 1'b1;
            end
            COMPUTE: m[CH_COMPUTE] = 1'b1;
            STORE:   m[CH_STORE]   = 1'b1;
            default: m = '0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/multiplier_phase_sequencer_child.sv
// Per-child ap_start/ap_ready/ap_done handshake: start-pending bit and done latch.
// The parent masks ready/done so only the owning phase reaches this block.
module seq_child_handshake (
    input  logic ap_clk,
    input  logic ap_rst_n,
    input  logic arm,
    input  logic abort,
    input  logic child_ready,
    input  logic child_done,
    output logic child_start,
    output logic done_seen
);

    logic pend_q, pend_d;
    logic seen_q, seen_d;

    always_comb begin
        pend_d = pend_q;
        seen_d = seen_q;
        if (abort) begin
            pend_d = 1'b0;
            seen_d = 1'b0;
        end else if (arm) begin
            pend_d = 1'b1;
            seen_d = 1'b0;
        end else begin
            if (child_ready) pend_d = 1'b0;
            if (child_done)  seen_d = 1'b1;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            pend_q <= 1'b0;
            seen_q <= 1'b0;
        end else begin
            pend_q <= pend_d;
            seen_q <= seen_d;
        end
    end

    assign child_start = pend_q;
    assign done_seen   = seen_q;

endmodule

// File: rtl/multiplier_phase_sequencer.sv
// Phase sequencer for the matrix multiplier: load-A, load-B, compute, store,
// with run-latency capture and per-phase watchdog. Build option SEQ_OVERLAP_LOAD_EN
// runs both loads concurrently in LOAD_AB.
module multiplier_phase_sequencer
    import multiplier_seq_pkg::*;
#(
    parameter int unsigned CNT_W          = 32,
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic               ap_clk,
    input  logic               ap_rst_n,
    input  logic               ap_start,
    output logic               ap_ready,
    output logic               ap_done,
    output logic               ap_idle,
    input  logic               ap_continue,
    output logic [N_CHILD-1:0] child_start,
    input  logic [N_CHILD-1:0] child_ready,
    input  logic [N_CHILD-1:0] child_done,
    output logic [2:0]         phase,
    output logic [CNT_W-1:0]   run_cycles,
    output logic               timeout_err
);

    seq_state_e         state_q, state_d;
    logic               ready_q;
    logic               tmo_q, tmo_d;
    logic [CNT_W-1:0]   run_cnt_q, run_cnt_d;
    logic [CNT_W-1:0]   run_cycles_q, run_cycles_d;
    logic [CNT_W-1:0]   wd_q, wd_d;

    logic [N_CHILD-1:0] own, arm, done_seen, ready_g, done_g;
    logic               accept, phase_cmpl, wd_abort, done_entry;

    assign own     = phase_owner(state_q);
    assign arm     = phase_owner(state_d) & ~own;
    assign ready_g = child_ready & own;
    assign done_g  = child_done & own;

    // A phase is complete when every owned child has reported done, now or earlier.
    assign phase_cmpl = (own != '0) && (((done_seen | done_g) & own) == own);

    for (genvar i = 0; i < N_CHILD; i++) begin : g_child
        seq_child_handshake u_hs (
            .ap_clk      (ap_clk),
            .ap_rst_n    (ap_rst_n),
            .arm         (arm[i]),
            .abort       (wd_abort),
            .child_ready (ready_g[i]),
            .child_done  (done_g[i]),
            .child_start (child_start[i]),
            .done_seen   (done_seen[i])
        );
    end

    if (TIMEOUT_CYCLES != 0) begin : g_wd
        assign wd_abort = (own != '0) && !phase_cmpl && (wd_q == CNT_W'(TIMEOUT_CYCLES));
    end else begin : g_no_wd
        assign wd_abort = 1'b0;
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (ap_start) begin
                    accept = 1'b1;
`ifdef SEQ_OVERLAP_LOAD_EN
                    state_d = LOAD_AB;
`else
                    state_d = LOAD_A;
`endif
                end
            end
            LOAD_A:  if (phase_cmpl) state_d = LOAD_B;
            LOAD_B:  if (phase_cmpl) state_d = COMPUTE;
            LOAD_AB: if (phase_cmpl) state_d = COMPUTE;
            COMPUTE: if (phase_cmpl) state_d = STORE;
            STORE:   if (phase_cmpl) state_d = DONE;
            DONE:    if (ap_continue) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (wd_abort) state_d = DONE;
    end

    assign done_entry = (state_d == DONE) && (state_q != DONE);

    always_comb begin
        run_cnt_d    = run_cnt_q;
        run_cycles_d = run_cycles_q;
        wd_d         = wd_q;
        tmo_d        = tmo_q;
        if (accept) begin
            run_cnt_d = CNT_W'(1);
        end else if (own != '0 && run_cnt_q != '1) begin
            run_cnt_d = run_cnt_q + CNT_W'(1);
        end
        if (done_entry) run_cycles_d = run_cnt_q;
        // Phase counter reads 1 in the first cycle of every phase.
        if (state_d != state_q) begin
            wd_d = CNT_W'(1);
        end else if (wd_q != '1) begin
            wd_d = wd_q + CNT_W'(1);
        end
        if (accept) begin
            tmo_d = 1'b0;
        end else if (wd_abort) begin
            tmo_d = 1'b1;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q      <= IDLE;
            ready_q      <= 1'b0;
            tmo_q        <= 1'b0;
            run_cnt_q    <= '0;
            run_cycles_q <= '0;
            wd_q         <= '0;
        end else begin
            state_q      <= state_d;
            ready_q      <= accept;
            tmo_q        <= tmo_d;
            run_cnt_q    <= run_cnt_d;
            run_cycles_q <= run_cycles_d;
            wd_q         <= wd_d;
        end
    end

    assign ap_ready    = ready_q;
    assign ap_done     = (state_q == DONE);
    assign ap_idle     = (state_q == IDLE);
    assign phase       = state_q;
    assign run_cycles  = run_cycles_q;
    assign timeout_err = tmo_q;

endmodule
